// File: rtl/umi_port_arbiter.sv
// Per-output-port arbiter for the UMI crossbar: fixed / round-robin / aging modes with a requester mask.
// Latency: zero; the grant is combinational from requests, mask and registered state.
// Backpressure: a grant issued while out_ready=0 is locked and held until accepted or its request drops.
module umi_port_arbiter #(
  parameter  int N    = 4,
  parameter  int AGEW = 4,
  localparam int IW   = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic [1:0]    mode,
  input  logic [N-1:0]  mask,
  input  logic [N-1:0]  requests,
  input  logic          out_ready,
  output logic [N-1:0]  grants,
  output logic [IW-1:0] grant_idx,
  output logic          out_valid
);

  localparam logic [N-1:0]    ONE_N    = {{(N-1){1'b0}}, 1'b1};
  localparam logic [AGEW-1:0] AGE_MAX  = '1;
  localparam logic [AGEW-1:0] AGE_ONE  = {{(AGEW-1){1'b0}}, 1'b1};

  logic            lock;
  logic [N-1:0]    locked_grant;
  logic [N-1:0]    rr_ptr;
  logic [AGEW-1:0] age [N];

  logic [N-1:0]    eligible;
  logic [N-1:0]    urgent;
  logic [N-1:0]    rr_hi;
  logic [N-1:0]    arb_grant;
  logic [N-1:0]    grant_int;
  logic            lock_hold;
  logic            accept;

  // Isolate the lowest set bit (two's complement trick).
  function automatic logic [N-1:0] lowest(input logic [N-1:0] v);
    lowest = v & (~v + ONE_N);
  endfunction

  // Eligibility and urgency per requester.
  always_comb begin
    eligible = requests & ~mask;
    urgent   = '0;
    for (int i = 0; i < N; i++) begin
      urgent[i] = eligible[i] && (age[i] == AGE_MAX);
    end
  end

  // Eligible requesters at or above the round-robin pointer (rr_ptr is one-hot).
  assign rr_hi = eligible & ~(rr_ptr - ONE_N);

  // Fresh arbitration according to mode; 11 behaves as round-robin.
  always_comb begin
    arb_grant = '0;
    case (mode)
      2'b00:   arb_grant = lowest(eligible);
      2'b10:   arb_grant = (|urgent) ? lowest(urgent) : lowest(eligible);
      default: arb_grant = (|rr_hi) ? lowest(rr_hi) : lowest(eligible);
    endcase
  end

  // A locked grant overrides arbitration only while its request is still up;
  // if the request drops, the lock is abandoned and we arbitrate this cycle.
  assign lock_hold = lock && (|(locked_grant & requests));
  assign grant_int = lock_hold ? locked_grant : arb_grant;

  // Reset forces the outputs low immediately, not just at the next edge.
  assign grants    = nreset ? grant_int : '0;
  assign out_valid = |grants;
  assign accept    = out_valid & out_ready;

  // Binary index of the granted requester.
  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (grants[i]) grant_idx = IW'(i);
    end
  end

  // Lock whenever a grant is outstanding but not accepted; re-capturing the
  // held grant keeps the lock stable across a multi-cycle stall.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      lock         <= 1'b0;
      locked_grant <= '0;
    end else begin
      lock         <= out_valid & ~out_ready;
      locked_grant <= grants;
    end
  end

  // Round-robin pointer advances past the winner on each accept in RR modes.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rr_ptr <= ONE_N;
    end else if (accept && mode[0]) begin
      rr_ptr <= {grants[N-2:0], grants[N-1]};
    end
  end

  // Saturating age per requester: cleared on accept or idle, bumped while waiting.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < N; i++) begin
        age[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (!requests[i] || (accept && grants[i])) begin
          age[i] <= '0;
        end else if (eligible[i] && (age[i] != AGE_MAX)) begin
          age[i] <= age[i] + AGE_ONE;
        end
      end
    end
  end

endmodule
